rvfi_retire_monitor: RTL and testbench

//  Synthesisable formal/sim monitor on a core's RVFI retirement port, generalised to NRET lanes and XLEN.
//  Per lane: checks the retirement against externally instanced ISA spec models (spec_* inputs).

---
 rtl/rvfi_mon_pkg.sv | 28 ++
 rtl/rvfi_lane_check.sv | 48 ++++
 rtl/rvfi_retire_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_rvfi_retire_monitor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retirement monitor: error causes, FSM states and opcode constants.
// The optional SYSTEM-instruction exemption is controlled by RVFI_MON_SYSTEM_EXEMPT_EN.
package rvfi_mon_pkg;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_PACK  = 3'd1,
    ERR_ORDER = 3'd2,
    ERR_PCSEQ = 3'd3,
    ERR_SPEC  = 3'd4,
    ERR_RD    = 3'd5,
    ERR_PCW   = 3'd6,
    ERR_X0    = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } mon_state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_system(input logic [6:0] opcode);
    return opcode == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/rvfi_lane_check.sv
// Combinational per-lane comparison of one retirement against the ISA spec model (causes SPEC..X0).
// With RVFI_MON_SYSTEM_EXEMPT_EN defined, SYSTEM-opcode lanes skip the spec comparisons like traps do.
module rvfi_lane_check
  import rvfi_mon_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            trap,
  input  logic [ILEN-1:0] insn,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_wdata,
  input  logic [XLEN-1:0] pc_wdata,
  input  logic            spec_valid,
  input  logic            spec_trap,
  input  logic [4:0]      spec_rd_addr,
  input  logic [XLEN-1:0] spec_rd_wdata,
  input  logic [XLEN-1:0] spec_pc_wdata,
  output err_code_e       code
);

  logic exempt;
  logic unused_insn;

  assign unused_insn = ^insn;

`ifdef RVFI_MON_SYSTEM_EXEMPT_EN
  assign exempt = trap | is_system(insn[6:0]);
`else
  assign exempt = trap;
`endif

  // Checks are applied highest cause first so the lowest failing cause overrides.
  // NOTE: assigning a default before any condition keeps always_comb free of inferred latches.
  always_comb begin
    code = ERR_NONE;
    if (rd_addr == 5'd0 && rd_wdata != '0)
      code = ERR_X0;
    if (!exempt && pc_wdata != spec_pc_wdata)
      code = ERR_PCW;
    if (!exempt && (rd_addr != spec_rd_addr ||
                    (rd_addr != 5'd0 && rd_wdata != spec_rd_wdata)))
      code = ERR_RD;
    if (!exempt && (!spec_valid || spec_trap))
      code = ERR_SPEC;
  end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement monitor: lane packing, order/PC sequencing and spec-model checks with a sticky
// first-error record and saturating retire/trap counters. Option: RVFI_MON_SYSTEM_EXEMPT_EN.
module rvfi_retire_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int NRET   = 1,
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int WARMUP = 2,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*64-1:0]     rvfi_order,
  input  logic [NRET*ILEN-1:0]   rvfi_insn,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  input  logic [NRET-1:0]        spec_valid,
  input  logic [NRET-1:0]        spec_trap,
  input  logic [NRET*5-1:0]      spec_rd_addr,
  input  logic [NRET*XLEN-1:0]   spec_rd_wdata,
  input  logic [NRET*XLEN-1:0]   spec_pc_wdata,
  output logic                   checking,
  output logic                   err,
  output logic [2:0]             err_code,
  output logic [$clog2(NRET):0]  err_lane,
  output logic [63:0]            err_order,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [CNT_W-1:0]       trap_cnt
);

  localparam int LANE_W = $clog2(NRET) + 1;
  localparam int WC_W   = $clog2(WARMUP + 2);
  localparam int SUM_W  = CNT_W + 1;

  mon_state_e       state;
  logic [WC_W-1:0]  warm_cnt;
  logic             warm_done;
  logic [63:0]      exp_order;
  logic [XLEN-1:0]  last_pc;
  logic             have_pc;

  logic [NRET*3-1:0] lane_code;
  logic              hit;
  logic [2:0]        hit_code;
  logic [LANE_W-1:0] hit_lane;
  logic [63:0]       hit_order;
  logic [2:0]        k;
  logic [2:0]        k_trap;
  logic [XLEN-1:0]   hi_pc;
  logic [63:0]       hi_order;
  logic [SUM_W-1:0]  ret_sum;
  logic [SUM_W-1:0]  trap_sum;

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    logic [63:0]     ord;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_prev;
    logic            prev_ok;
    logic            pc_chk;
    err_code_e       spec_code;
    err_code_e       code;

    assign ord  = rvfi_order[g*64 +: 64];
    assign pc_r = rvfi_pc_rdata[g*XLEN +: XLEN];

    // Lane 0 continues from the previous cycle; higher lanes continue from the lane below.
    if (g == 0) begin : g_first
      assign prev_ok = 1'b1;
      assign pc_chk  = have_pc;
      assign pc_prev = last_pc;
    end else begin : g_rest
      assign prev_ok = rvfi_valid[g-1];
      assign pc_chk  = 1'b1;
      assign pc_prev = rvfi_pc_wdata[(g-1)*XLEN +: XLEN];
    end

    rvfi_lane_check #(
      .XLEN(XLEN),
      .ILEN(ILEN)
    ) u_check (
      .trap          (rvfi_trap[g]),
      .insn          (rvfi_insn[g*ILEN +: ILEN]),
      .rd_addr       (rvfi_rd_addr[g*5 +: 5]),
      .rd_wdata      (rvfi_rd_wdata[g*XLEN +: XLEN]),
      .pc_wdata      (rvfi_pc_wdata[g*XLEN +: XLEN]),
      .spec_valid    (spec_valid[g]),
      .spec_trap     (spec_trap[g]),
      .spec_rd_addr  (spec_rd_addr[g*5 +: 5]),
      .spec_rd_wdata (spec_rd_wdata[g*XLEN +: XLEN]),
      .spec_pc_wdata (spec_pc_wdata[g*XLEN +: XLEN]),
      .code          (spec_code)
    );

    always_comb begin
      code = spec_code;
      if (pc_chk && pc_r != pc_prev)
        code = ERR_PCSEQ;
      if (ord != exp_order + 64'(g))
        code = ERR_ORDER;
      if (!prev_ok)
        code = ERR_PACK;
      if (!rvfi_valid[g])
        code = ERR_NONE;
    end

    assign lane_code[g*3 +: 3] = code;
  end

  // Scanning downward lets the lowest failing lane win.
  always_comb begin
    hit       = 1'b0;
    hit_code  = '0;
    hit_lane  = '0;
    hit_order = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (lane_code[i*3 +: 3] != 3'd0) begin
        hit       = 1'b1;
        hit_code  = lane_code[i*3 +: 3];
        hit_lane  = LANE_W'(i);
        hit_order = rvfi_order[i*64 +: 64];
      end
    end
  end

  always_comb begin
    k        = '0;
    k_trap   = '0;
    hi_pc    = last_pc;
    hi_order = exp_order;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        k        = k + 3'd1;
        hi_pc    = rvfi_pc_wdata[i*XLEN +: XLEN];
        hi_order = rvfi_order[i*64 +: 64];
        if (rvfi_trap[i])
          k_trap = k_trap + 3'd1;
      end
    end
  end

  assign warm_done = (int'(warm_cnt) + 1 >= WARMUP);
  assign ret_sum   = {1'b0, retired_cnt} + SUM_W'(k);
  assign trap_sum  = {1'b0, trap_cnt} + SUM_W'(k_trap);
  assign checking  = (state == CHECK);

  // NOTE: all state here is written with non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WARM;
      warm_cnt    <= '0;
      exp_order   <= '0;
      last_pc     <= '0;
      have_pc     <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      err_lane    <= '0;
      err_order   <= '0;
      retired_cnt <= '0;
      trap_cnt    <= '0;
    end else begin
      // During warm-up the observed stream seeds the expected order instead of being checked.
      if (|rvfi_valid) begin
        last_pc   <= hi_pc;
        have_pc   <= 1'b1;
        exp_order <= (state == WARM) ? hi_order + 64'd1 : exp_order + 64'(k);
      end

      if (state != FAIL) begin
        retired_cnt <= ret_sum[CNT_W]  ? '1 : ret_sum[CNT_W-1:0];
        trap_cnt    <= trap_sum[CNT_W] ? '1 : trap_sum[CNT_W-1:0];
      end

      case (state)
        WARM: begin
          if (warm_done)
            state <= CHECK;
          else
            warm_cnt <= warm_cnt + 1'b1;
        end
        CHECK: begin
          if (hit) begin
            state     <= FAIL;
            err       <= 1'b1;
            err_code  <= hit_code;
            err_lane  <= hit_lane;
            err_order <= hit_order;
          end
        end
        FAIL:    state <= FAIL;
        default: state <= WARM;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Self-checking bench for rvfi_retire_monitor (NRET=2, WARMUP=2, CNT_W=8): vector table,
// hand-written corner sequences and random stimulus against a rule-level reference model.
module tb_rvfi_retire_monitor;

  localparam int NRET    = 2;
  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int WARMUP  = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                  clk;
  logic                  reset;
  logic [NRET*64-1:0]    rvfi_order;
  logic [NRET*ILEN-1:0]  rvfi_insn;
  logic [NRET*XLEN-1:0]  rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [NRET*5-1:0]     rvfi_rd_addr, spec_rd_addr;
  logic [NRET*XLEN-1:0]  spec_rd_wdata, spec_pc_wdata;
  logic                  checking, err;
  logic [2:0]            err_code;
  logic [1:0]            err_lane;
  logic [63:0]           err_order;
  logic [CNT_W-1:0]      retired_cnt, trap_cnt;

  logic [1:0]  v_valid, v_trap, s_valid, s_trap;
  logic [63:0] v_order [2];
  logic [31:0] v_insn [2];
  logic [31:0] v_pc_r [2];
  logic [31:0] v_pc_w [2];
  logic [4:0]  v_rd_a [2];
  logic [31:0] v_rd_w [2];
  logic [4:0]  s_rd_a [2];
  logic [31:0] s_rd_w [2];
  logic [31:0] s_pc_w [2];

  assign rvfi_order    = {v_order[1], v_order[0]};
  assign rvfi_insn     = {v_insn[1], v_insn[0]};
  assign rvfi_pc_rdata = {v_pc_r[1], v_pc_r[0]};
  assign rvfi_pc_wdata = {v_pc_w[1], v_pc_w[0]};
  assign rvfi_rd_addr  = {v_rd_a[1], v_rd_a[0]};
  assign rvfi_rd_wdata = {v_rd_w[1], v_rd_w[0]};
  assign spec_rd_addr  = {s_rd_a[1], s_rd_a[0]};
  assign spec_rd_wdata = {s_rd_w[1], s_rd_w[0]};
  assign spec_pc_wdata = {s_pc_w[1], s_pc_w[0]};

  rvfi_retire_monitor #(
    .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .WARMUP(WARMUP), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rvfi_valid    (v_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_trap     (v_trap),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .spec_valid    (s_valid),
    .spec_trap     (s_trap),
    .spec_rd_addr  (spec_rd_addr),
    .spec_rd_wdata (spec_rd_wdata),
    .spec_pc_wdata (spec_pc_wdata),
    .checking      (checking),
    .err           (err),
    .err_code      (err_code),
    .err_lane      (err_lane),
    .err_order     (err_order),
    .retired_cnt   (retired_cnt),
    .trap_cnt      (trap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the monitor's observable behaviour from the rule list.
  int          m_warm_left;
  bit          m_err;
  int          m_code, m_lane, m_ret, m_trp;
  logic [63:0] m_order, m_exp;
  logic [31:0] m_last_pc;
  bit          m_have;

  task automatic model_reset();
    m_warm_left = WARMUP;
    m_err = 0; m_code = 0; m_lane = 0; m_order = '0;
    m_ret = 0; m_trp = 0; m_exp = '0; m_last_pc = '0; m_have = 0;
  endtask

  function automatic int model_lane(input int i);
    bit skip;
    skip = v_trap[i];
`ifdef RVFI_MON_SYSTEM_EXEMPT_EN
    if (v_insn[i][6:0] == 7'h73) skip = 1'b1;
`endif
    if (i > 0) begin
      if (!v_valid[i-1]) return 1;
    end
    if (v_order[i] != m_exp + 64'(i)) return 2;
    if (i == 0) begin
      if (m_have && v_pc_r[0] != m_last_pc) return 3;
    end else if (v_pc_r[i] != v_pc_w[i-1]) return 3;
    if (!skip && (!s_valid[i] || s_trap[i])) return 4;
    if (!skip && (v_rd_a[i] != s_rd_a[i] || (v_rd_a[i] != 0 && v_rd_w[i] != s_rd_w[i]))) return 5;
    if (!skip && v_pc_w[i] != s_pc_w[i]) return 6;
    if (v_rd_a[i] == 0 && v_rd_w[i] != 0) return 7;
    return 0;
  endfunction

  task automatic model_step();
    bit in_warm, was_err;
    int hi, k, kt, c;
    in_warm = (m_warm_left > 0);
    was_err = m_err;
    hi = -1; k = 0; kt = 0;
    for (int i = 0; i < NRET; i++) begin
      if (v_valid[i]) begin
        hi = i; k++;
        if (v_trap[i]) kt++;
      end
    end
    if (!in_warm && !m_err) begin
      for (int i = 0; i < NRET; i++) begin
        if (v_valid[i] && !m_err) begin
          c = model_lane(i);
          if (c != 0) begin
            m_err = 1; m_code = c; m_lane = i; m_order = v_order[i];
          end
        end
      end
    end
    if (!was_err) begin
      m_ret = (m_ret + k > CNT_MAX) ? CNT_MAX : m_ret + k;
      m_trp = (m_trp + kt > CNT_MAX) ? CNT_MAX : m_trp + kt;
    end
    if (hi >= 0) begin
      m_exp     = in_warm ? v_order[hi] + 64'd1 : m_exp + 64'(k);
      m_last_pc = v_pc_w[hi];
      m_have    = 1;
    end
    if (in_warm) m_warm_left--;
  endtask

  task automatic compare_model();
    check("err", err, m_err);
    check("err_code", err_code, 64'(m_code));
    check("err_lane", err_lane, 64'(m_lane));
    check("err_order", err_order, m_order);
    check("checking", checking, (m_warm_left == 0 && !m_err));
    check("retired_cnt", retired_cnt, 64'(m_ret));
    check("trap_cnt", trap_cnt, 64'(m_trp));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic clear_lanes();
    v_valid = '0; v_trap = '0; s_valid = '0; s_trap = '0;
    for (int i = 0; i < NRET; i++) begin
      v_order[i] = '0; v_insn[i] = '0; v_pc_r[i] = '0; v_pc_w[i] = '0;
      v_rd_a[i] = '0; v_rd_w[i] = '0; s_rd_a[i] = '0; s_rd_w[i] = '0; s_pc_w[i] = '0;
    end
  endtask

  task automatic set_lane(input int i, input logic [63:0] ord, input logic [31:0] pc);
    v_valid[i] = 1'b1; v_trap[i] = 1'b0; v_order[i] = ord; v_insn[i] = NOP;
    v_pc_r[i] = pc; v_pc_w[i] = pc + 32'd4;
    v_rd_a[i] = 5'(i + 1); v_rd_w[i] = pc ^ 32'h55;
    s_valid[i] = 1'b1; s_trap[i] = 1'b0;
    s_rd_a[i] = v_rd_a[i]; s_rd_w[i] = v_rd_w[i]; s_pc_w[i] = v_pc_w[i];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clear_lanes();
      cycle();
    end
  endtask

  task automatic do_reset();
    clear_lanes();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_err_lane", err_lane, 0);
    check("rst_err_order", err_order, 0);
    check("rst_checking", checking, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_trap", trap_cnt, 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_cycle(input bit allow_fault);
    int r, f, kind;
    for (int i = 0; i < NRET; i++) begin
      v_order[i] = {$urandom, $urandom}; v_insn[i] = $urandom;
      v_pc_r[i] = $urandom; v_pc_w[i] = $urandom;
      v_rd_a[i] = 5'($urandom); v_rd_w[i] = $urandom;
      s_rd_a[i] = 5'($urandom); s_rd_w[i] = $urandom; s_pc_w[i] = $urandom;
      v_trap[i] = 1'($urandom); s_valid[i] = 1'($urandom); s_trap[i] = 1'($urandom);
    end
    r = $urandom_range(0, 9);
    v_valid = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : 2'b11;
    for (int i = 0; i < NRET; i++) begin
      if (v_valid[i]) begin
        v_order[i] = (m_warm_left > 0) ? {$urandom, $urandom} : m_exp + 64'(i);
        if (i == 0) v_pc_r[0] = m_have ? m_last_pc : ($urandom & 32'hFFFF_FFFC);
        else        v_pc_r[i] = v_pc_w[i-1];
        v_pc_w[i] = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : v_pc_r[i] + 32'd4;
        v_insn[i] = NOP;
        v_rd_a[i] = 5'($urandom_range(0, 31));
        v_rd_w[i] = (v_rd_a[i] == 0) ? 32'd0 : $urandom;
        v_trap[i] = ($urandom_range(0, 5) == 0);
        if (!v_trap[i]) begin
          s_valid[i] = 1'b1; s_trap[i] = 1'b0;
          s_rd_a[i] = v_rd_a[i]; s_rd_w[i] = v_rd_w[i]; s_pc_w[i] = v_pc_w[i];
        end
      end
    end
    if (allow_fault && v_valid != 2'b00 && $urandom_range(0, 14) == 0) begin
      f = (v_valid == 2'b11) ? $urandom_range(0, 1) : 0;
      kind = $urandom_range(0, 7);
      case (kind)
        0: v_order[f] = v_order[f] + 64'd1;
        1: v_pc_r[f] = v_pc_r[f] ^ 32'h8;
        2: s_valid[f] = 1'b0;
        3: begin v_rd_a[f] = 5'd1; s_rd_a[f] = 5'd1; v_rd_w[f] = 32'h11; s_rd_w[f] = 32'h12; end
        4: s_pc_w[f] = s_pc_w[f] ^ 32'h4;
        5: begin v_rd_a[f] = 5'd0; s_rd_a[f] = 5'd0; v_rd_w[f] = 32'd1; s_rd_w[f] = 32'd1; end
        6: v_valid = 2'b10;
        default: begin v_insn[f] = 32'h73; s_valid[f] = 1'b0; end
      endcase
    end
    cycle();
  endtask

  typedef struct {
    logic        trap, sv, st;
    logic [31:0] insn;
    logic [4:0]  rda;
    logic [31:0] rdw;
    logic [4:0]  srda;
    logic [31:0] srdw, pcw, spcw;
    logic [2:0]  code;
    int          trapc;
  } vec_t;

  vec_t vec[$];

  initial begin
    reset = 1'b0;
    clear_lanes();
    model_reset();

    // Single lane-0 retirement right after warm-up; spec-side faults and their resulting cause.
    vec.push_back('{0, 1, 0, NOP, 3, 5, 3, 5, 4, 4, 3'd0, 0});
    vec.push_back('{0, 0, 0, NOP, 3, 5, 3, 5, 4, 4, 3'd4, 0});
    vec.push_back('{0, 1, 1, NOP, 3, 5, 3, 5, 4, 4, 3'd4, 0});
    vec.push_back('{0, 1, 0, NOP, 3, 5, 4, 5, 4, 4, 3'd5, 0});
    vec.push_back('{0, 1, 0, NOP, 3, 5, 3, 6, 4, 4, 3'd5, 0});
    vec.push_back('{1, 1, 0, NOP, 3, 5, 3, 6, 4, 4, 3'd0, 1});
    vec.push_back('{0, 1, 0, NOP, 0, 0, 0, 9, 4, 4, 3'd0, 0});
    vec.push_back('{0, 1, 0, NOP, 3, 5, 3, 5, 8, 4, 3'd6, 0});
    vec.push_back('{0, 1, 0, NOP, 0, 1, 0, 1, 4, 4, 3'd7, 0});
    vec.push_back('{1, 1, 0, NOP, 0, 1, 0, 1, 4, 4, 3'd7, 1});
    vec.push_back('{0, 0, 0, NOP, 3, 5, 3, 5, 8, 4, 3'd4, 0});
    vec.push_back('{1, 0, 0, NOP, 3, 5, 7, 1, 8, 4, 3'd0, 1});
    vec.push_back('{0, 1, 0, NOP, 3, 5, 3, 6, 8, 4, 3'd5, 0});
`ifdef RVFI_MON_SYSTEM_EXEMPT_EN
    vec.push_back('{0, 0, 0, 32'h73, 0, 0, 0, 0, 4, 4, 3'd0, 0});
`else
    vec.push_back('{0, 0, 0, 32'h73, 0, 0, 0, 0, 4, 4, 3'd4, 0});
`endif

    foreach (vec[t]) begin
      do_reset();
      idle(2);
      clear_lanes();
      set_lane(0, 64'd0, 32'd0);
      v_trap[0] = vec[t].trap; s_valid[0] = vec[t].sv; s_trap[0] = vec[t].st;
      v_insn[0] = vec[t].insn;
      v_rd_a[0] = vec[t].rda; v_rd_w[0] = vec[t].rdw;
      s_rd_a[0] = vec[t].srda; s_rd_w[0] = vec[t].srdw;
      v_pc_w[0] = vec[t].pcw; s_pc_w[0] = vec[t].spcw;
      cycle();
      check($sformatf("vec%0d_err", t), err, (vec[t].code != 3'd0));
      check($sformatf("vec%0d_code", t), err_code, vec[t].code);
      check($sformatf("vec%0d_trap_cnt", t), trap_cnt, 64'(vec[t].trapc));
      check($sformatf("vec%0d_retired", t), retired_cnt, 1);
    end

    // Clean single-lane stream after three idle cycles.
    do_reset();
    idle(3);
    check("t1_checking_idle", checking, 1);
    for (int n = 0; n < 3; n++) begin
      clear_lanes();
      set_lane(0, 64'(n), 32'(4 * n));
      cycle();
    end
    check("t1_err", err, 0);
    check("t1_retired", retired_cnt, 3);
    check("t1_checking", checking, 1);

    // Order seeded at the top of the 64-bit range wraps to zero.
    do_reset();
    clear_lanes();
    set_lane(0, 64'hFFFF_FFFF_FFFF_FFFE, 32'd0);
    set_lane(1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd4);
    cycle();
    idle(1);
    set_lane(0, 64'd0, 32'd8);
    set_lane(1, 64'd1, 32'd12);
    cycle();
    check("wrap_err", err, 0);
    check("wrap_retired", retired_cnt, 4);

    // Lane 1 retires without lane 0.
    do_reset();
    idle(2);
    clear_lanes();
    set_lane(1, 64'd5, 32'd0);
    cycle();
    check("t2_err", err, 1);
    check("t2_code", err_code, 1);
    check("t2_lane", err_lane, 1);
    check("t2_order", err_order, 5);

    // Order gap, then a later error must not overwrite the record.
    do_reset();
    clear_lanes();
    set_lane(0, 64'd5, 32'd0);
    cycle();
    idle(1);
    set_lane(0, 64'd7, 32'd4);
    cycle();
    check("t3_code", err_code, 2);
    check("t3_order", err_order, 7);
    clear_lanes();
    set_lane(1, 64'd9, 32'd0);
    cycle();
    check("t3_sticky_code", err_code, 2);
    check("t3_sticky_order", err_order, 7);
    check("t3_checking", checking, 0);
    check("t3_frozen_retired", retired_cnt, 2);

    // PC discontinuity is ignored in warm-up but caught once checking.
    do_reset();
    clear_lanes();
    set_lane(0, 64'd0, 32'h100);
    cycle();
    set_lane(0, 64'd1, 32'h100);
    cycle();
    check("t4_warm_err", err, 0);
    set_lane(0, 64'd2, 32'h100);
    cycle();
    check("t4_err", err, 1);
    check("t4_code", err_code, 3);

    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      repeat (50) rand_cycle(1'b1);
    end

    do_reset();
    repeat (300) rand_cycle(1'b0);
    check("sat_retired", retired_cnt, CNT_MAX);
    check("sat_err", err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
